// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: circular buffer of DEPTH entries whose
// operands are captured from the CDB; only the head entry may issue.
module ls_issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     dispatch_enable,
  input  logic [XLEN-1:0]          dispatch_rs1_data,
  input  logic [XLEN-1:0]          dispatch_rs2_data,
  input  logic [TAG_W-1:0]         dispatch_rs1_tag,
  input  logic [TAG_W-1:0]         dispatch_rs2_tag,
  input  logic                     dispatch_rs1_valid,
  input  logic                     dispatch_rs2_valid,
  input  logic [XLEN-1:0]          dispatch_imm,
  input  logic [TAG_W-1:0]         dispatch_rd_tag,
  input  logic                     dispatch_is_store,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  output logic                     issueque_full,
  output logic                     issueque_empty,
  output logic [$clog2(DEPTH):0]   issueque_count,
  output logic                     issueque_ready,
  output logic [XLEN-1:0]          issueque_rs_data,
  output logic [XLEN-1:0]          issueque_rt_data,
  output logic [XLEN-1:0]          issueque_imm,
  output logic [TAG_W-1:0]         issueque_rd_tag,
  output logic                     issueque_opcode,
  input  logic                     issueblk_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d, s1v_q, s1v_d, s2v_q, s2v_d, st_q, st_d;
  logic [TAG_W-1:0] s1t_q [DEPTH];
  logic [TAG_W-1:0] s1t_d [DEPTH];
  logic [TAG_W-1:0] s2t_q [DEPTH];
  logic [TAG_W-1:0] s2t_d [DEPTH];
  logic [TAG_W-1:0] rd_q  [DEPTH];
  logic [TAG_W-1:0] rd_d  [DEPTH];
  logic [XLEN-1:0]  s1d_q [DEPTH];
  logic [XLEN-1:0]  s1d_d [DEPTH];
  logic [XLEN-1:0]  s2d_q [DEPTH];
  logic [XLEN-1:0]  s2d_d [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [XLEN-1:0]  imm_d [DEPTH];

  logic head_vld, push, pop, s1_byp, s2_byp;

  assign head_vld       = vld_q[head_q];
  assign issueque_full  = (count_q == CNT_W'(DEPTH));
  assign issueque_empty = (count_q == '0);
  assign issueque_count = count_q;
  assign issueque_ready = head_vld && s1v_q[head_q] && s2v_q[head_q];

  assign issueque_rs_data = head_vld ? s1d_q[head_q] : '0;
  assign issueque_rt_data = head_vld ? s2d_q[head_q] : '0;
  assign issueque_imm     = head_vld ? imm_q[head_q] : '0;
  assign issueque_rd_tag  = head_vld ? rd_q[head_q]  : '0;
  assign issueque_opcode  = head_vld && st_q[head_q];

  assign push   = dispatch_enable && !issueque_full && !flush;
  assign pop    = issueque_ready && issueblk_done && !flush;
  assign s1_byp = !dispatch_rs1_valid && cdb_valid && (dispatch_rs1_tag == cdb_tag);
  assign s2_byp = !dispatch_rs2_valid && cdb_valid && (dispatch_rs2_tag == cdb_tag);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    s1v_d   = s1v_q;
    s2v_d   = s2v_q;
    st_d    = st_q;
    s1t_d   = s1t_q;
    s2t_d   = s2t_q;
    rd_d    = rd_q;
    s1d_d   = s1d_q;
    s2d_d   = s2d_q;
    imm_d   = imm_q;
    if (flush) begin
      vld_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Wakeup: every waiting operand of a live entry snoops the broadcast.
      if (cdb_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (vld_q[i] && !s1v_q[i] && (s1t_q[i] == cdb_tag)) begin
            s1v_d[i] = 1'b1;
            s1d_d[i] = cdb_data;
          end
          if (vld_q[i] && !s2v_q[i] && (s2t_q[i] == cdb_tag)) begin
            s2v_d[i] = 1'b1;
            s2d_d[i] = cdb_data;
          end
        end
      end
      if (pop) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + 1'b1;
      end
      // The tail slot is never live when not full, so it cannot collide with wakeup.
      if (push) begin
        vld_d[tail_q] = 1'b1;
        s1v_d[tail_q] = dispatch_rs1_valid || s1_byp;
        s2v_d[tail_q] = dispatch_rs2_valid || s2_byp;
        s1d_d[tail_q] = s1_byp ? cdb_data : dispatch_rs1_data;
        s2d_d[tail_q] = s2_byp ? cdb_data : dispatch_rs2_data;
        s1t_d[tail_q] = dispatch_rs1_tag;
        s2t_d[tail_q] = dispatch_rs2_tag;
        imm_d[tail_q] = dispatch_imm;
        rd_d[tail_q]  = dispatch_rd_tag;
        st_d[tail_q]  = dispatch_is_store;
        tail_d        = tail_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      s1v_q   <= '0;
      s2v_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
      s1v_q   <= s1v_d;
      s2v_q   <= s2v_d;
    end
  end

  // Payload is only observable through a live entry, so it carries no reset.
  always_ff @(posedge clk) begin
    st_q  <= st_d;
    s1t_q <= s1t_d;
    s2t_q <= s2t_d;
    rd_q  <= rd_d;
    s1d_q <= s1d_d;
    s2d_q <= s2d_d;
    imm_q <= imm_d;
  end

endmodule

// File: tb/tb_ls_issue_queue.sv
// Bench for ls_issue_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ls_issue_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic reset, flush, dispatch_enable;
  logic [XLEN-1:0] dispatch_rs1_data, dispatch_rs2_data, dispatch_imm, cdb_data;
  logic [TAG_W-1:0] dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rd_tag, cdb_tag;
  logic dispatch_rs1_valid, dispatch_rs2_valid, dispatch_is_store, cdb_valid, issueblk_done;
  logic issueque_full, issueque_empty, issueque_ready, issueque_opcode;
  logic [$clog2(DEPTH):0] issueque_count;
  logic [XLEN-1:0] issueque_rs_data, issueque_rt_data, issueque_imm;
  logic [TAG_W-1:0] issueque_rd_tag;

  ls_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .dispatch_enable(dispatch_enable),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs2_valid(dispatch_rs2_valid),
    .dispatch_imm(dispatch_imm), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_is_store(dispatch_is_store), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .issueque_full(issueque_full), .issueque_empty(issueque_empty),
    .issueque_count(issueque_count), .issueque_ready(issueque_ready),
    .issueque_rs_data(issueque_rs_data), .issueque_rt_data(issueque_rt_data),
    .issueque_imm(issueque_imm), .issueque_rd_tag(issueque_rd_tag),
    .issueque_opcode(issueque_opcode), .issueblk_done(issueblk_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents in program order.
  typedef struct {
    logic v1, v2, st;
    logic [TAG_W-1:0] t1, t2, rd;
    logic [XLEN-1:0] d1, d2, imm;
  } ent_t;
  ent_t mq[$];
  ent_t ne;
  logic m_pop, m_push;

  always @(posedge clk) begin
    if (reset || flush) begin
      mq.delete();
    end else begin
      m_pop  = (mq.size() > 0) && mq[0].v1 && mq[0].v2 && issueblk_done;
      m_push = dispatch_enable && (mq.size() < DEPTH);
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].v1 && mq[i].t1 == cdb_tag) begin mq[i].v1 = 1'b1; mq[i].d1 = cdb_data; end
          if (!mq[i].v2 && mq[i].t2 == cdb_tag) begin mq[i].v2 = 1'b1; mq[i].d2 = cdb_data; end
        end
      end
      if (m_pop) mq.delete(0);
      if (m_push) begin
        ne.v1 = dispatch_rs1_valid; ne.d1 = dispatch_rs1_data; ne.t1 = dispatch_rs1_tag;
        ne.v2 = dispatch_rs2_valid; ne.d2 = dispatch_rs2_data; ne.t2 = dispatch_rs2_tag;
        if (!ne.v1 && cdb_valid && ne.t1 == cdb_tag) begin ne.v1 = 1'b1; ne.d1 = cdb_data; end
        if (!ne.v2 && cdb_valid && ne.t2 == cdb_tag) begin ne.v2 = 1'b1; ne.d2 = cdb_data; end
        ne.imm = dispatch_imm; ne.rd = dispatch_rd_tag; ne.st = dispatch_is_store;
        mq.push_back(ne);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", issueque_count, mq.size());
      chk("full", issueque_full, mq.size() == DEPTH);
      chk("empty", issueque_empty, mq.size() == 0);
      if (mq.size() == 0) begin
        chk("ready", issueque_ready, 0);
        chk("rs_data", issueque_rs_data, 0);
        chk("rt_data", issueque_rt_data, 0);
        chk("imm", issueque_imm, 0);
        chk("rd_tag", issueque_rd_tag, 0);
        chk("opcode", issueque_opcode, 0);
      end else begin
        chk("ready", issueque_ready, mq[0].v1 && mq[0].v2);
        chk("rs_data", issueque_rs_data, mq[0].d1);
        chk("rt_data", issueque_rt_data, mq[0].d2);
        chk("imm", issueque_imm, mq[0].imm);
        chk("rd_tag", issueque_rd_tag, mq[0].rd);
        chk("opcode", issueque_opcode, mq[0].st);
      end
    end
  end

  task automatic idle();
    reset = 0; flush = 0; dispatch_enable = 0; issueblk_done = 0; cdb_valid = 0;
    cdb_tag = 0; cdb_data = 0;
    dispatch_rs1_data = 0; dispatch_rs2_data = 0; dispatch_imm = 0;
    dispatch_rs1_tag = 0; dispatch_rs2_tag = 0; dispatch_rd_tag = 0;
    dispatch_rs1_valid = 1; dispatch_rs2_valid = 1; dispatch_is_store = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [XLEN-1:0] d1, input logic v1, input logic [TAG_W-1:0] t1,
                      input logic [TAG_W-1:0] rd, input logic st);
    dispatch_enable = 1; dispatch_rs1_data = d1; dispatch_rs1_valid = v1; dispatch_rs1_tag = t1;
    dispatch_rs2_data = d1 ^ 32'hFFFF; dispatch_rs2_valid = 1; dispatch_imm = d1 + 7;
    dispatch_rd_tag = rd; dispatch_is_store = st;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_count", issueque_count, 0);
    chk("rst_empty", issueque_empty, 1);
    chk("rst_full", issueque_full, 0);
    chk("rst_ready", issueque_ready, 0);
    chk("rst_rs", issueque_rs_data, 0);
    idle();

    // Fill to full, then an ignored ninth dispatch.
    for (int i = 0; i < 8; i++) begin
      disp(32'h100 + i, 1, 0, TAG_W'(i), i[0]);
      step();
    end
    chk("fill_full", issueque_full, 1);
    chk("fill_count", issueque_count, 8);
    chk("fill_head_rs", issueque_rs_data, 32'h100);
    chk("fill_head_op", issueque_opcode, 0);
    disp(32'h999, 1, 0, 6'd33, 0);
    step();
    chk("ninth_count", issueque_count, 8);
    chk("ninth_full", issueque_full, 1);
    idle();
    issueblk_done = 1;
    repeat (3) step();
    chk("pop3_count", issueque_count, 5);
    chk("pop3_rs", issueque_rs_data, 32'h103);
    chk("pop3_op", issueque_opcode, 1);

    // Flush with a same-cycle dispatch: nothing survives.
    idle();
    flush = 1;
    disp(32'h555, 1, 0, 6'd40, 0);
    step();
    idle();
    chk("flush_count", issueque_count, 0);
    chk("flush_empty", issueque_empty, 1);
    chk("flush_ready", issueque_ready, 0);
    chk("flush_rs", issueque_rs_data, 0);

    // Wakeup of the head from the CDB is visible one cycle later.
    disp(32'h0, 0, 6'd5, 6'd1, 0);
    step();
    idle();
    chk("wait_ready", issueque_ready, 0);
    cdb_valid = 1; cdb_tag = 6'd5; cdb_data = 32'h1234;
    #1 chk("cdb_same_cycle", issueque_ready, 0);
    step();
    idle();
    chk("wake_ready", issueque_ready, 1);
    chk("wake_rs", issueque_rs_data, 32'h1234);
    issueblk_done = 1;
    step();
    idle();

    // Bypass on dispatch into rs2.
    dispatch_enable = 1; dispatch_rs2_valid = 0; dispatch_rs2_tag = 6'd9; dispatch_rd_tag = 6'd2;
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'hABCD;
    step();
    idle();
    chk("byp_ready", issueque_ready, 1);
    chk("byp_rt", issueque_rt_data, 32'hABCD);
    issueblk_done = 1;
    step();
    idle();

    // Blocked head with a ready younger entry behind it.
    disp(32'h77, 0, 6'd3, 6'd20, 0);
    step();
    disp(32'h88, 1, 0, 6'd21, 1);
    step();
    idle();
    issueblk_done = 1;
    repeat (3) step();
    chk("blk_count", issueque_count, 2);
    chk("blk_rd", issueque_rd_tag, 20);
    chk("blk_rs", issueque_rs_data, 32'h77);
    cdb_valid = 1; cdb_tag = 6'd3; cdb_data = 32'h55;
    step();
    cdb_valid = 0;
    chk("unblk_count", issueque_count, 2);
    chk("unblk_rs", issueque_rs_data, 32'h55);
    step();
    chk("order_rd", issueque_rd_tag, 21);
    step();
    chk("order_empty", issueque_empty, 1);
    idle();

    // Steady push+pop at count 3, wrapping the pointers.
    for (int i = 0; i < 3; i++) begin
      disp(32'h200 + i, 1, 0, TAG_W'(i), 0);
      step();
    end
    for (int j = 0; j < 10; j++) begin
      disp(32'h203 + j, 1, 0, TAG_W'(3 + j), 0);
      issueblk_done = 1;
      chk("pp_rd_pre", issueque_rd_tag, j);
      step();
      chk("pp_count", issueque_count, 3);
      chk("pp_rd", issueque_rd_tag, j + 1);
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      disp(32'h300 + i, 1, 0, 6'd50, 0);
      step();
    end
    idle();
    chk("pre_rst_count", issueque_count, 5);

    // Reset mid-operation with a dispatch pending.
    reset = 1;
    disp(32'h444, 1, 0, 6'd41, 1);
    step();
    idle();
    chk("mrst_count", issueque_count, 0);
    chk("mrst_empty", issueque_empty, 1);
    chk("mrst_ready", issueque_ready, 0);
    chk("mrst_rd", issueque_rd_tag, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 79) == 0);
      dispatch_enable = ($urandom_range(0, 3) != 0);
      dispatch_rs1_valid = $urandom_range(0, 1);
      dispatch_rs2_valid = $urandom_range(0, 1);
      dispatch_rs1_tag = TAG_W'($urandom_range(0, 7));
      dispatch_rs2_tag = TAG_W'($urandom_range(0, 7));
      dispatch_rs1_data = $urandom();
      dispatch_rs2_data = $urandom();
      dispatch_imm = $urandom();
      dispatch_rd_tag = TAG_W'($urandom());
      dispatch_is_store = $urandom_range(0, 1);
      cdb_valid = $urandom_range(0, 1);
      cdb_tag = TAG_W'($urandom_range(0, 7));
      cdb_data = $urandom();
      issueblk_done = ($urandom_range(0, 2) != 0);
      step();
    end
    idle();
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ls_issue_queue.md
LS_ISSUE_QUEUE -- requirements
Module: ls_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, meaning operand/immediate width.
REQ-003 SHALL have parameter TAG_W, default 6, meaning CDB/rename tag width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush  input  1  discard all entries.
REQ-007 SHALL have port dispatch_enable  input  1  dispatch request.
REQ-008 SHALL have ports dispatch_rs1_data / dispatch_rs2_data  input  XLEN  source operands.
REQ-009 SHALL have ports dispatch_rs1_tag / dispatch_rs2_tag  input  TAG_W  producer tags.
REQ-010 SHALL have ports dispatch_rs1_valid / dispatch_rs2_valid  input  1  operand already valid.
REQ-011 SHALL have ports dispatch_imm  input  XLEN, dispatch_rd_tag  input  TAG_W, dispatch_is_store  input  1.
REQ-012 SHALL have ports cdb_valid  input  1, cdb_tag  input  TAG_W, cdb_data  input  XLEN.
REQ-013 SHALL have ports issueque_full  output  1, issueque_empty  output  1, issueque_count  output  $clog2(DEPTH)+1.
REQ-014 SHALL have ports issueque_ready  output  1, issueque_rs_data / issueque_rt_data / issueque_imm  output  XLEN, issueque_rd_tag  output  TAG_W, issueque_opcode  output  1 (1=store).
REQ-015 SHALL have port issueblk_done  input  1  unit accepts the head entry this cycle.

Function
REQ-016 SHALL be a circular buffer: head and tail pointers wrap modulo DEPTH, with no entry shifting.
REQ-017 SHALL issue strictly in order; only the head entry may issue.
REQ-018 SHALL drive issueque_full = (count==DEPTH) and issueque_empty = (count==0), both purely registered-state functions with no dependence on issueblk_done.
REQ-019 SHALL accept a dispatch (push) when dispatch_enable && !issueque_full && !flush: write the tail entry, set it valid, advance tail.
REQ-020 SHALL ignore dispatch_enable while full, leaving state unchanged.
REQ-021 SHALL assert issueque_ready when the head entry is valid and both operand-valid bits are set, and drive the outputs from the head entry combinationally.
REQ-022 SHALL pop when issueque_ready && issueblk_done && !flush: invalidate the head entry and advance head; issueblk_done without ready SHALL be ignored.
REQ-023 SHALL support simultaneous push and pop in one cycle (count unchanged), including at count==DEPTH-1; a push while full is refused even if a pop occurs that cycle.
REQ-024 SHALL, on cdb_valid, set data and valid bits for every valid entry operand whose valid bit is 0 and whose tag equals cdb_tag; rs1 and rs2 of one entry may both capture in the same cycle.
REQ-025 SHALL apply CDB bypass on push: a dispatched operand with valid=0 and tag==cdb_tag while cdb_valid stores cdb_data with valid=1.
REQ-026 SHALL make a CDB broadcast to the head entry visible on issueque_ready no earlier than the next cycle.
REQ-027 SHALL, on flush, clear all valid bits, reset head/tail/count to 0, and ignore same-cycle dispatch, pop, and CDB updates.
REQ-028 SHALL drive issueque_rs_data/rt_data/imm/rd_tag/opcode to 0 when the head entry is invalid.

Reset
REQ-029 SHALL, on reset high at a clock edge, clear all entries and pointers, giving count=0, empty=1, full=0, ready=0, and all data outputs 0.
REQ-030 SHALL give reset priority over flush, dispatch, CDB, and issue; reset asserted mid-operation discards all entries on that edge.

Verification
REQ-031 Push 8 entries (DEPTH=8), all operands valid, issueblk_done=0 -> full=1 after the 8th edge; a 9th dispatch is ignored; count stays 8.
REQ-032 Push entry A with rs1_valid=0, rs1_tag=5, then cdb_valid=1, cdb_tag=5, cdb_data=0x1234 -> next cycle ready=1, issueque_rs_data=0x1234.
REQ-033 Push with rs2_valid=0, tag=9 in the same cycle as cdb_valid/tag=9/data=0xABCD -> entry stored with rs2 valid; ready=1 the next cycle.
REQ-034 With count=3 and head ready, drive dispatch and issueblk_done together for 10 cycles -> count stays 3, outputs follow FIFO order, and pointers wrap past index 7 correctly.
REQ-035 Head waiting (rs1 invalid), younger entry ready -> younger never issues before head; issueblk_done without ready leaves count unchanged.
REQ-036 Flush or reset asserted with count=5 -> the next cycle shows count=0, empty=1, ready=0, outputs 0; a same-cycle dispatch is not stored.
